// File: rtl/encode_packet.sv
// encode_packet: segments a DFX frame into numbered Aurora words tagged with the source router ID
module encode_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19,
  parameter int PAYLOAD_WIDTH     = 55
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_encode_pkt,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
  input  logic [1:0]                   src_router,
  output logic                         ready_encode_pkt,
  output logic [AURORA_DATA_WIDTH-1:0] data_send,
  output logic                         valid_send,
  input  logic                         ready_send,
  output logic                         encode_done
);
  localparam int PAD_WIDTH = NUMBER_PACKET * PAYLOAD_WIDTH;
  localparam logic [4:0] LAST = 5'(NUMBER_PACKET - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [DATA_DFX_WIDTH-1:0] frame_q, frame_d;
  logic [1:0] router_q, router_d;
  logic [AURORA_DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  function automatic logic [AURORA_DATA_WIDTH-1:0] word(input logic [DATA_DFX_WIDTH-1:0] f, input logic [4:0] k, input logic [1:0] r);
    logic [PAD_WIDTH-1:0] p;
    p = '0;
    p[DATA_DFX_WIDTH-1:0] = f;
    return {p[int'(k)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH], 2'b00, k, r};
  endfunction
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    router_d = router_q;
    data_d   = data_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: if (start_encode_pkt) begin
        state_d  = SEND;
        cnt_d    = '0;
        frame_d  = data_dfx_send;
        router_d = src_router;
      end
      SEND: if (!valid_q) begin
        valid_d = 1'b1;
        data_d  = word(frame_q, cnt_q, router_q);
      end else if (ready_send) begin
        state_d = cnt_q == LAST ? DONE : SEND;
        valid_d = cnt_q != LAST;
        cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 5'd1;
        data_d  = cnt_q == LAST ? '0 : word(frame_q, cnt_q + 5'd1, router_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      router_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      router_q <= router_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end
  assign ready_encode_pkt = state_q == IDLE;
  assign encode_done      = state_q == DONE;
  assign valid_send       = valid_q;
  assign data_send        = data_q;
endmodule

// File: tb/tb_encode_packet.sv
// tb_encode_packet: directed vector table plus reset and back-to-back sequences for encode_packet
module tb_encode_packet;
  logic clk = 1'b0;
  logic rst;
  logic start_encode_pkt;
  logic [1033:0] data_dfx_send;
  logic [1:0] src_router;
  logic ready_encode_pkt;
  logic [63:0] data_send;
  logic valid_send;
  logic ready_send;
  logic encode_done;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [1033:0] frame;
    logic [1:0] router;
    logic [1033:0] alt_frame;
    logic [1:0] alt_router;
    bit bp;
    bit pulse;
    bit hold;
    bit hand;
    int lat;
    logic [63:0] w0;
    logic [63:0] w18;
  } vec_t;
  vec_t vecs[6];
  logic [1033:0] fa, f1, f2, f3, f4;
  encode_packet dut (
    .clk(clk), .rst(rst), .start_encode_pkt(start_encode_pkt), .data_dfx_send(data_dfx_send),
    .src_router(src_router), .ready_encode_pkt(ready_encode_pkt), .data_send(data_send),
    .valid_send(valid_send), .ready_send(ready_send), .encode_done(encode_done)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] exp_word(input logic [1033:0] f, input int k, input logic [1:0] r);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 55; b++)
      if (k * 55 + b < 1034) w[9 + b] = f[k * 55 + b];
    w[6:2] = 5'(k);
    w[1:0] = r;
    return w;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int id);
    logic pv, rdy;
    logic [63:0] pd;
    int k, done_at;
    @(negedge clk);
    start_encode_pkt = 1'b1;
    data_dfx_send = v.frame;
    src_router = v.router;
    ready_send = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d accept", id), 64'(ready_encode_pkt), 64'd0);
    k = 0;
    done_at = -1;
    pv = valid_send;
    pd = data_send;
    for (int n = 1; n <= 80 && done_at < 0; n++) begin
      rdy = v.bp ? (n % 3 == 2) : 1'b1;
      ready_send = rdy;
      data_dfx_send = v.alt_frame;
      src_router = v.alt_router;
      start_encode_pkt = v.hold ? 1'b1 : (v.pulse ? 1'(n % 2) : 1'b0);
      @(posedge clk); #1;
      if (pv && rdy) begin
        check($sformatf("v%0d word%0d", id, k), pd, exp_word(v.frame, k, v.router));
        if (v.hand && k == 0) check($sformatf("v%0d word0_const", id), pd, v.w0);
        if (v.hand && k == 18) check($sformatf("v%0d word18_const", id), pd, v.w18);
        k++;
      end else if (pv) begin
        check($sformatf("v%0d hold_data", id), data_send, pd);
        check($sformatf("v%0d hold_valid", id), 64'(valid_send), 64'd1);
      end
      if (encode_done) done_at = n;
      pv = valid_send;
      pd = data_send;
    end
    check($sformatf("v%0d word_count", id), 64'(k), 64'd19);
    check($sformatf("v%0d done_latency", id), 64'(done_at), 64'(v.lat));
    if (!v.hold) start_encode_pkt = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d done_single", id), 64'(encode_done), 64'd0);
    check($sformatf("v%0d idle_valid", id), 64'(valid_send), 64'd0);
    check($sformatf("v%0d idle_ready", id), 64'(ready_encode_pkt), 64'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int xfers;
    bit saw_done;
    logic pv;
    for (int i = 0; i < 1034; i++) begin
      fa[i] = 1'(i % 2);
      f1[i] = 1'($urandom);
      f2[i] = 1'($urandom);
      f3[i] = 1'($urandom);
      f4[i] = 1'($urandom);
    end
    vecs[0] = '{frame:fa, router:2'd2, alt_frame:fa, alt_router:2'd2, bp:0, pulse:0, hold:0, hand:1, lat:20,
                w0:64'h5555_5555_5555_5402, w18:64'h0015_5555_5555_544A};
    vecs[1] = '{frame:f1, router:2'd1, alt_frame:f1, alt_router:2'd1, bp:1, pulse:0, hold:0, hand:0, lat:56, w0:'0, w18:'0};
    vecs[2] = '{frame:f2, router:2'd0, alt_frame:~f2, alt_router:2'd3, bp:0, pulse:1, hold:0, hand:0, lat:20, w0:'0, w18:'0};
    vecs[3] = '{frame:f3, router:2'd0, alt_frame:f4, alt_router:2'd1, bp:0, pulse:0, hold:1, hand:0, lat:20, w0:'0, w18:'0};
    vecs[4] = '{frame:f4, router:2'd1, alt_frame:f4, alt_router:2'd1, bp:0, pulse:0, hold:0, hand:0, lat:20, w0:'0, w18:'0};
    vecs[5] = '{frame:{1034{1'b1}}, router:2'd3, alt_frame:'0, alt_router:2'd0, bp:0, pulse:0, hold:0, hand:0, lat:20, w0:'0, w18:'0};
    rst = 1'b1;
    start_encode_pkt = 1'b0;
    data_dfx_send = '0;
    src_router = '0;
    ready_send = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset ready", 64'(ready_encode_pkt), 64'd1);
    check("reset valid", 64'(valid_send), 64'd0);
    check("reset data", data_send, 64'd0);
    check("reset done", 64'(encode_done), 64'd0);
    for (int i = 0; i < 5; i++) run(vecs[i], i);
    @(negedge clk);
    start_encode_pkt = 1'b1;
    data_dfx_send = f1;
    src_router = 2'd1;
    ready_send = 1'b1;
    @(posedge clk); #1;
    start_encode_pkt = 1'b0;
    xfers = 0;
    pv = valid_send;
    for (int i = 0; i < 40 && xfers < 8; i++) begin
      @(posedge clk); #1;
      if (pv) xfers++;
      pv = valid_send;
    end
    check("midreset transfers", 64'(xfers), 64'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset valid", 64'(valid_send), 64'd0);
    check("midreset data", data_send, 64'd0);
    check("midreset done", 64'(encode_done), 64'd0);
    check("midreset ready", 64'(ready_encode_pkt), 64'd1);
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (encode_done || valid_send) saw_done = 1'b1;
    end
    check("midreset no_resume", 64'(saw_done), 64'd0);
    run(vecs[5], 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
